// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, LSB-first data, optional parity, stop period.
// Optional parity bit is compiled in with the UART_TX_PARITY_EN macro.
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  tx_busy,
    output logic                  tx_done_tick,
    output logic                  txd
);

    localparam int S_W = $clog2((SB_TICK > 16) ? SB_TICK : 16);
    localparam int N_W = $clog2(DATA_WIDTH);

    localparam logic [S_W-1:0] S_BIT_END  = S_W'(15);
    localparam logic [S_W-1:0] S_STOP_END = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST     = N_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    localparam int ST_W = 3;
`else
    localparam int ST_W = 2;
`endif

    localparam logic [ST_W-1:0] IDLE   = ST_W'(0);
    localparam logic [ST_W-1:0] START  = ST_W'(1);
    localparam logic [ST_W-1:0] DATA   = ST_W'(2);
    localparam logic [ST_W-1:0] STOP   = ST_W'(3);
`ifdef UART_TX_PARITY_EN
    localparam logic [ST_W-1:0] PARITY = ST_W'(4);
`endif

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 ||
        (SB_TICK != 16 && SB_TICK != 24 && SB_TICK != 32) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
        $error("uart_tx: illegal parameter value");
    end

    logic [ST_W-1:0]       state, state_n;
    logic [S_W-1:0]        s, s_n;
    logic [N_W-1:0]        n, n_n;
    logic [DATA_WIDTH-1:0] b, b_n;
    logic                  done_n;
    logic                  txd_n;
`ifdef UART_TX_PARITY_EN
    // The shift register is drained by the time parity goes out, so the bit is latched at acceptance.
    logic                  par, par_n;
`endif

    assign tx_ready = (state == IDLE);
    assign tx_busy  = (state != IDLE);

    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    b_n     = tx_data;
                    s_n     = '0;
                    n_n     = '0;
                    state_n = START;
`ifdef UART_TX_PARITY_EN
                    par_n   = (^tx_data) ^ PARITY_ODD[0];
`endif
                end
            end
            START: begin
                if (tick) begin
                    if (s == S_BIT_END) begin
                        s_n     = '0;
                        state_n = DATA;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s == S_BIT_END) begin
                        s_n = '0;
                        b_n = b >> 1;
                        if (n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            n_n = n + 1'b1;
                        end
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s == S_BIT_END) begin
                        s_n     = '0;
                        state_n = STOP;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s == S_STOP_END) begin
                        s_n     = '0;
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level follows the next state so txd changes on the same edge as the FSM.
        txd_n = 1'b1;
        case (state_n)
            START:  txd_n = 1'b0;
            DATA:   txd_n = b_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY: txd_n = par_n;
`endif
            default: txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            txd          <= 1'b1;
            tx_done_tick <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par          <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            s            <= s_n;
            n            <= n_n;
            b            <= b_n;
            txd          <= txd_n;
            tx_done_tick <= done_n;
`ifdef UART_TX_PARITY_EN
            par          <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frames, hand sequences and random frames
// compared every cycle against a tick-counting frame model.
module tb_uart_tx;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int SB = 32;
    localparam int PB = 1;
`else
    localparam int SB = 16;
    localparam int PB = 0;
`endif
    localparam int PODD   = 0;
    localparam int TOTAL  = 16 * (1 + DW) + 16 * PB + SB;
    localparam int BUDGET = 8 * TOTAL + 50;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_ready, tx_busy, tx_done_tick, txd;

    uart_tx #(.DATA_WIDTH(DW), .SB_TICK(SB), .PARITY_ODD(PODD)) dut (
        .clk(clk), .reset(reset), .tick(tick), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .txd(txd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a frame is a list of 16-tick bit slots counted from acceptance.
    bit            m_busy = 1'b0;
    bit            m_done = 1'b0;
    int            m_k = 0;
    logic [DW-1:0] m_data = '0;
    int            tick_mode = 0;
    int            div_cnt = 0;
    logic          cap[$];

    typedef struct {
        logic [7:0] data;
        int         mode;
        logic       exp_even;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_txd();
        int idx;
        if (!m_busy) return 1'b1;
        idx = m_k / 16;
        if (idx == 0) return 1'b0;
        if (idx <= DW) return m_data[idx-1];
        if (PB == 1 && idx == DW + 1) return (^m_data) ^ 1'(PODD);
        return 1'b1;
    endfunction

    task automatic cycle();
        @(negedge clk);
        if (tick_mode == 0) begin
            tick = (div_cnt == 3);
            div_cnt = (div_cnt + 1) % 4;
        end else begin
            tick = !tick && ($urandom_range(0, 2) == 0);
        end
        @(posedge clk);
        m_done = 1'b0;
        if (!reset) begin
            m_busy = 1'b0;
            m_k = 0;
        end else if (!m_busy) begin
            if (tx_valid) begin
                m_busy = 1'b1;
                m_k = 0;
                m_data = tx_data;
            end
        end else if (tick) begin
            m_k++;
            if (m_k == TOTAL) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
        #1;
        chk("txd", txd, exp_txd());
        chk("tx_ready", tx_ready, !m_busy);
        chk("tx_busy", tx_busy, m_busy);
        chk("tx_done_tick", tx_done_tick, m_done);
        if (m_busy && tick && (m_k % 16 == 8)) cap.push_back(txd);
    endtask

    function automatic logic [DW-1:0] get_word();
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < DW; i++)
            if (cap.size() > 1 + i) w[i] = cap[1+i];
        return w;
    endfunction

    task automatic wait_done(input string name);
        for (int c = 0; c < BUDGET && tx_done_tick !== 1'b1; c++) cycle();
        chk(name, tx_done_tick, 1'b1);
    endtask

    task automatic run_frame(input logic [DW-1:0] d, input bit inject,
                             output logic [DW-1:0] word, output logic par);
        bit injected;
        int ticks;
        injected = 1'b0;
        ticks = 0;
        cap.delete();
        tx_valid = 1'b1;
        tx_data = d;
        cycle();
        tx_valid = 1'b0;
        tx_data = DW'($urandom);
        chk("accept_busy", tx_busy, 1'b1);
        for (int c = 0; c < BUDGET && tx_done_tick !== 1'b1; c++) begin
            if (inject && !injected && m_k >= 40) begin
                tx_valid = 1'b1;
                tx_data = 8'h3C;
                injected = 1'b1;
            end else begin
                tx_valid = 1'b0;
            end
            cycle();
            if (tick) ticks++;
        end
        tx_valid = 1'b0;
        chk("done_seen", tx_done_tick, 1'b1);
        chk("frame_ticks", ticks, TOTAL);
        chk("sample_count", cap.size(), 1 + DW + PB + (SB + 7) / 16);
        chk("start_bit", (cap.size() > 0) ? cap[0] : 1'bx, 1'b0);
        chk("stop_bit", (cap.size() > 0) ? cap[cap.size()-1] : 1'bx, 1'b1);
        word = get_word();
        par = (PB == 1 && cap.size() > DW + 1) ? cap[DW+1] : 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] w;
        logic          p;

        tbl[0] = '{8'hA5, 0, 1'b0};
        tbl[1] = '{8'h00, 1, 1'b0};
        tbl[2] = '{8'hFF, 0, 1'b0};
        tbl[3] = '{8'h07, 1, 1'b1};
        tbl[4] = '{8'h3C, 0, 1'b0};
        tbl[5] = '{8'h01, 1, 1'b1};
        tbl[6] = '{8'h80, 0, 1'b1};
        tbl[7] = '{8'h5A, 1, 1'b0};

        // Reset held with random inputs
        #3 reset = 1'b0;
        tick_mode = 1;
        for (int i = 0; i < 5; i++) begin
            tx_valid = 1'($urandom);
            tx_data = DW'($urandom);
            cycle();
        end
        chk("reset_txd", txd, 1'b1);
        chk("reset_busy", tx_busy, 1'b0);
        tx_valid = 1'b0;
        reset = 1'b1;
        cycle();
        cycle();

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            tick_mode = tbl[i].mode;
            run_frame(tbl[i].data, 1'b0, w, p);
            chk("table_word", w, tbl[i].data);
            if (PB == 1) chk("table_parity", p, tbl[i].exp_even ^ 1'(PODD));
            cycle();
        end

        // Back-to-back with tx_valid held
        tick_mode = 0;
        cap.delete();
        tx_valid = 1'b1;
        tx_data = 8'h00;
        cycle();
        wait_done("b2b_first_done");
        chk("b2b_first_word", get_word(), 8'h00);
        chk("b2b_ready_in_done", tx_ready, 1'b1);
        tx_data = 8'hFF;
        cap.delete();
        cycle();
        chk("b2b_accept", tx_busy, 1'b1);
        chk("b2b_start_no_gap", txd, 1'b0);
        tx_valid = 1'b0;
        wait_done("b2b_second_done");
        chk("b2b_second_word", get_word(), 8'hFF);

        // Request during DATA is ignored
        run_frame(8'hA5, 1'b1, w, p);
        chk("ignored_word", w, 8'hA5);
        for (int i = 0; i < 20; i++) cycle();
        chk("ignored_idle", tx_busy, 1'b0);

        // Reset during data bit 3
        tx_valid = 1'b1;
        tx_data = 8'hA5;
        cycle();
        tx_valid = 1'b0;
        for (int c = 0; c < BUDGET && m_k < 68; c++) cycle();
        chk("pre_reset_busy", tx_busy, 1'b1);
        chk("pre_reset_txd", txd, 1'b0);
        #2 reset = 1'b0;
        #1;
        m_busy = 1'b0;
        m_done = 1'b0;
        chk("abort_txd", txd, 1'b1);
        chk("abort_busy", tx_busy, 1'b0);
        chk("abort_ready", tx_ready, 1'b1);
        chk("abort_done", tx_done_tick, 1'b0);
        cycle();
        cycle();
        reset = 1'b1;
        run_frame(8'h96, 1'b0, w, p);
        chk("post_reset_word", w, 8'h96);

        // Random frames
        for (int r = 0; r < 20; r++) begin
            logic [DW-1:0] d;
            int gap;
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) cycle();
            tick_mode = $urandom_range(0, 1);
            d = DW'($urandom);
            run_frame(d, 1'($urandom), w, p);
            chk("random_word", w, d);
            if (PB == 1) chk("random_parity", p, (^d) ^ 1'(PODD));
        end
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
